// File: rtl/frame_assembler.sv
// Assembles a raster-order pixel stream into a double-buffered R_I x C_I frame.
// A full frame waits in the write buffer while the previous frame is still held on img.
module frame_assembler #(
    parameter int unsigned R_I = 5,
    parameter int unsigned C_I = 5,
    parameter int unsigned W_I = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [W_I-1:0]                       s_data,
    input  logic                                 s_sof,
    output logic [R_I-1:0][C_I-1:0][W_I-1:0]     img,
    output logic                                 img_valid,
    input  logic                                 img_ready,
    output logic                                 sof_err
);

    localparam int unsigned RW = (R_I > 1) ? $clog2(R_I) : 1;
    localparam int unsigned CW = (C_I > 1) ? $clog2(C_I) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FULL} state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [RW-1:0]                      r_row;
    logic [CW-1:0]                      r_col;
    logic [R_I-1:0][C_I-1:0][W_I-1:0]   r_wbuf;
    logic [R_I-1:0][C_I-1:0][W_I-1:0]   r_img;
    logic                               r_img_valid;
    logic                               r_sof_err;

    logic                               w_acc;
    logic                               w_wr;
    logic                               w_start;
    logic                               w_last;
    logic                               w_err;
    logic                               w_slot_free;
    logic [RW-1:0]                      w_wr_row;
    logic [CW-1:0]                      w_wr_col;
    logic [RW-1:0]                      w_row_nxt;
    logic [CW-1:0]                      w_col_nxt;
    logic [R_I-1:0][C_I-1:0][W_I-1:0]   w_wbuf_nxt;

    // Write address, merged buffer and counter advance for the accepted beat.
    always_comb begin
        w_acc       = s_valid && s_ready;
        w_start     = w_acc && s_sof;
        w_wr        = w_acc && (s_sof || (r_state == ST_FILL));
        w_err       = w_acc && (((r_state == ST_IDLE) && !s_sof) ||
                                ((r_state == ST_FILL) &&  s_sof));
        w_slot_free = !r_img_valid || img_ready;
        w_wr_row    = w_start ? '0 : r_row;
        w_wr_col    = w_start ? '0 : r_col;
        w_last      = w_wr && (w_wr_row == RW'(R_I - 1)) && (w_wr_col == CW'(C_I - 1));
        w_wbuf_nxt  = r_wbuf;
        if (w_wr) begin
            w_wbuf_nxt[w_wr_row][w_wr_col] = s_data;
        end
        w_row_nxt = w_wr_row;
        w_col_nxt = w_wr_col + CW'(1);
        if (w_last) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
        end else if (w_wr_col == CW'(C_I - 1)) begin
            w_row_nxt = w_wr_row + RW'(1);
            w_col_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_wr) begin
                    if (w_last) begin
                        w_state_nxt = w_slot_free ? ST_IDLE : ST_FULL;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_FULL: begin
                if (img_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = rstn && (r_state != ST_FULL);
    end

    // Datapath: write buffer, counters, output slot and error pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_row       <= '0;
            r_col       <= '0;
            r_wbuf      <= '0;
            r_img       <= '0;
            r_img_valid <= 1'b0;
            r_sof_err   <= 1'b0;
        end else begin
            r_sof_err <= w_err;
            if (w_wr) begin
                r_wbuf <= w_wbuf_nxt;
                r_row  <= w_row_nxt;
                r_col  <= w_col_nxt;
            end
            if (w_last && w_slot_free) begin
                r_img       <= w_wbuf_nxt;
                r_img_valid <= 1'b1;
            end else if ((r_state == ST_FULL) && img_ready) begin
                r_img       <= r_wbuf;
                r_img_valid <= 1'b1;
            end else if (r_img_valid && img_ready) begin
                r_img_valid <= 1'b0;
            end
        end
    end

    assign img       = r_img;
    assign img_valid = r_img_valid;
    assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler: expected frames queued at issue,
// popped and compared by a monitor on every img handshake.
module tb_frame_assembler;

    typedef logic [4:0][4:0][7:0] frame_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_sof;
    frame_t       img;
    logic         img_valid;
    logic         img_ready;
    logic         sof_err;

    int           total = 0;
    int           bad   = 0;
    int           err_cycles   = 0;
    int           valid_cycles = 0;
    int           n_taken      = 0;
    int           n_pushed     = 0;
    frame_t       exp_q[$];
    logic         rnd_done;

    frame_assembler #(.R_I(5), .C_I(5), .W_I(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .img       (img),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic frame_t fill(input logic [7:0] v);
        frame_t f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f[r][c] = v;
        return f;
    endfunction

    // Monitor: count pulses and compare each taken frame against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (sof_err)   err_cycles++;
            if (img_valid) valid_cycles++;
            if (img_valid && img_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_frame: got %h expected none", img);
                end else begin
                    chk_frame("frame", img, exp_q.pop_front());
                    n_taken++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input frame_t f);
        exp_q.push_back(f);
        n_pushed++;
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input logic sof);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("send_timeout", 32'(s_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < 25; i++)
            send(f[i / 5][i % 5], i == 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     e0;
        int     v0;
        int     n;

        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; img_ready = 1'b1;
        rnd_done = 1'b0;
        tick(); tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_img_valid", 32'(img_valid), 32'd0);
        chk("rst_sof_err", 32'(sof_err), 32'd0);
        chk_frame("rst_img", img, '0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Single frame, value = 5*row + col.
        for (int i = 0; i < 25; i++) f[i / 5][i % 5] = 8'(i);
        push(f);
        v0 = valid_cycles;
        send_frame(f);
        chk("t1_valid", 32'(img_valid), 32'd1);
        chk("t1_img23", 32'(img[2][3]), 32'd13);
        tick();
        chk("t1_valid_drop", 32'(img_valid), 32'd0);
        chk("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);

        // Backpressure: second frame waits in the write buffer.
        img_ready = 1'b0;
        push(fill(8'h11));
        send_frame(fill(8'h11));
        push(fill(8'h22));
        send_frame(fill(8'h22));
        chk("t2_s_ready_low", 32'(s_ready), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i % 5 == 0) begin
                chk_frame("t2_hold", img, fill(8'h11));
                chk("t2_hold_valid", 32'(img_valid), 32'd1);
            end
        end
        chk("t2_still_full", 32'(s_ready), 32'd0);
        img_ready = 1'b1;
        tick();
        chk_frame("t2_load", img, fill(8'h22));
        chk("t2_load_valid", 32'(img_valid), 32'd1);
        chk("t2_ready_back", 32'(s_ready), 32'd1);
        tick();
        chk("t2_valid_drop", 32'(img_valid), 32'd0);

        // Framing error: SOF on the 8th pixel restarts a frame of 0xAB.
        e0 = err_cycles;
        send(8'h01, 1'b1);
        for (int i = 2; i <= 7; i++) send(8'(i), 1'b0);
        push(fill(8'hAB));
        send_frame(fill(8'hAB));
        tick(); tick();
        chk("t3_err_pulses", 32'(err_cycles - e0), 32'd1);
        chk("t3_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame discards the partial frame and clears img.
        for (int i = 0; i < 12; i++) send(8'h50 + 8'(i), i == 0);
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_ready_in_rst", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("t5_valid", 32'(img_valid), 32'd0);
        chk_frame("t5_img_zero", img, '0);
        for (int i = 0; i < 25; i++) f[i / 5][i % 5] = 8'h80 + 8'(i);
        push(f);
        send_frame(f);
        tick();
        chk("t5_queue", 32'(exp_q.size()), 32'd0);

        // Missing SOF after reset.
        do_reset();
        e0 = err_cycles;
        v0 = valid_cycles;
        for (int i = 0; i < 3; i++) send(8'h33, 1'b0);
        tick(); tick(); tick();
        chk("t4_err_pulses", 32'(err_cycles - e0), 32'd3);
        chk("t4_no_valid", 32'(valid_cycles - v0), 32'd0);

        // Random frames with random input gaps and downstream stalls.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    for (int i = 0; i < 25; i++) f[i / 5][i % 5] = 8'($urandom);
                    push(f);
                    for (int i = 0; i < 25; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send(f[i / 5][i % 5], i == 0);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    img_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        img_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick(); tick();
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_taken", 32'(n_taken), 32'(n_pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
